// File: rtl/bcd_cascade_ctrl.sv
// Sequencing controller for a cascade of BCD counter digits: prescaled count tick,
// ripple-free carry enables, start/stop/clear/load control, target compare and wrap detect.
module bcd_cascade_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    input  logic [4*DIGITS-1:0] target,
    output logic [4*DIGITS-1:0] count,
    output logic [DIGITS-1:0]   digit_en,
    output logic                running,
    output logic                done,
    output logic                overflow
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t              state, state_nx;
    logic [PW-1:0]       presc, presc_nx;
    logic [4*DIGITS-1:0] count_nx, count_inc, load_clean;
    logic                tick, carry, wrap, overflow_nx;

    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] bcd_clean(input logic [3:0] d);
        return (d > 4'd9) ? 4'd0 : d;
    endfunction

    // A tick is suppressed when Clear or Load override the increment at this edge
    assign tick = (state == RUN) && (presc == PS_LAST) && !clear && !load;

    always_comb begin
        carry      = tick;
        digit_en   = '0;
        count_inc  = count;
        load_clean = '0;
        for (int k = 0; k < DIGITS; k++) begin
            digit_en[k] = carry;
            if (carry)
                count_inc[4*k +: 4] = bcd_inc(count[4*k +: 4]);
            carry = carry && (count[4*k +: 4] == 4'd9);
            load_clean[4*k +: 4] = bcd_clean(load_value[4*k +: 4]);
        end
        wrap = carry;
    end

    always_comb begin
        state_nx    = state;
        presc_nx    = presc;
        count_nx    = count;
        overflow_nx = 1'b0;
        if (clear) begin
            count_nx = '0;
            presc_nx = '0;
            state_nx = IDLE;
        end else if (load) begin
            count_nx = load_clean;
            presc_nx = '0;
            state_nx = IDLE;
        end else begin
            case (state)
                RUN: begin
                    // The tick's increment completes even when Stop arrives with it
                    presc_nx    = tick ? '0 : presc + 1'b1;
                    count_nx    = count_inc;
                    overflow_nx = wrap;
                    if (tick && (count_inc == target))
                        state_nx = DONE;
                    else if (stop)
                        state_nx = PAUSE;
                end
                IDLE, PAUSE: begin
                    if (!stop && start)
                        state_nx = RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            presc    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            presc    <= presc_nx;
            count    <= count_nx;
            overflow <= overflow_nx;
        end
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_bcd_cascade_ctrl.sv
// Directed bench for bcd_cascade_ctrl (DIGITS=2, PRESCALE=2) with a cycle-tagged scoreboard.
module tb_bcd_cascade_ctrl;

    localparam int DIGITS   = 2;
    localparam int PRESCALE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
    logic [7:0] load_value = 8'h00, target = 8'h00;
    logic [7:0] count;
    logic [1:0] digit_en;
    logic       running, done, overflow;

    bcd_cascade_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .load(load), .load_value(load_value), .target(target), .count(count),
        .digit_en(digit_en), .running(running), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          cyc;
        logic [12:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs are tagged with the cycle in which they must be visible
    always @(negedge clk) begin : monitor
        exp_t        t;
        logic [12:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            t   = sb.pop_front();
            act = {count, running, done, overflow, digit_en};
            checks++;
            if (t.cyc != cyc || act !== t.exp) begin
                errors++;
                $display("FAIL %s cyc %0d: got count=%h run=%b done=%b ovf=%b en=%b, want count=%h run=%b done=%b ovf=%b en=%b",
                         t.name, cyc, act[12:5], act[4], act[3], act[2], act[1:0],
                         t.exp[12:5], t.exp[4], t.exp[3], t.exp[2], t.exp[1:0]);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] c, input logic r,
                       input logic d, input logic o, input logic [1:0] e);
        exp_t t;
        t.name = name;
        t.cyc  = cyc;
        t.exp  = {c, r, d, o, e};
        sb.push_back(t);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        step(2);
        rst_n = 1'b1;
        chk("reset", 8'h00, 0, 0, 0, 2'b00);

        // Count to target 0x12
        target = 8'h12; start = 1'b1;
        step(1); start = 1'b0;
        chk("run_start",  8'h00, 1, 0, 0, 2'b00);
        step(1);  chk("tick1_en",   8'h00, 1, 0, 0, 2'b01);
        step(1);  chk("count01",    8'h01, 1, 0, 0, 2'b00);
        step(17); chk("carry_en",   8'h09, 1, 0, 0, 2'b11);
        step(1);  chk("count10",    8'h10, 1, 0, 0, 2'b00);
        step(4);  chk("done12",     8'h12, 0, 1, 0, 2'b00);
        step(4);  chk("done_hold",  8'h12, 0, 1, 0, 2'b00);

        // Load 0x98 and wrap the whole cascade
        load = 1'b1; load_value = 8'h98; target = 8'h50;
        step(1); load = 1'b0;
        chk("load98",     8'h98, 0, 0, 0, 2'b00);
        start = 1'b1;
        step(1); start = 1'b0;
        chk("run98",      8'h98, 1, 0, 0, 2'b00);
        step(1); chk("tick98_en",  8'h98, 1, 0, 0, 2'b01);
        step(1); chk("count99",    8'h99, 1, 0, 0, 2'b00);
        step(1); chk("carry99_en", 8'h99, 1, 0, 0, 2'b11);
        step(1); chk("wrap_ovf",   8'h00, 1, 0, 1, 2'b00);
        step(1); chk("ovf_pulse",  8'h00, 1, 0, 0, 2'b01);
        step(1); chk("after_wrap", 8'h01, 1, 0, 0, 2'b00);

        // Pause at 0x03 with prescaler held at 1
        step(4); chk("count03",    8'h03, 1, 0, 0, 2'b00);
        stop = 1'b1;
        step(1); stop = 1'b0;
        chk("pause",      8'h03, 0, 0, 0, 2'b00);
        step(10); chk("pause_hold", 8'h03, 0, 0, 0, 2'b00);
        start = 1'b1;
        step(1); start = 1'b0;
        chk("resume_tick", 8'h03, 1, 0, 0, 2'b01);
        step(1); chk("count04",    8'h04, 1, 0, 0, 2'b00);

        // Command priority and load sanitising
        step(6); chk("count07",    8'h07, 1, 0, 0, 2'b00);
        clear = 1'b1; load = 1'b1; start = 1'b1; load_value = 8'h3A;
        step(1); clear = 1'b0; start = 1'b0;
        chk("clear_wins", 8'h00, 0, 0, 0, 2'b00);
        step(1); load = 1'b0;
        chk("load3A",     8'h30, 0, 0, 0, 2'b00);

        // Stop coinciding with a matching tick
        load = 1'b1; load_value = 8'h05; target = 8'h06;
        step(1); load = 1'b0; start = 1'b1;
        step(1); start = 1'b0;
        chk("run05",      8'h05, 1, 0, 0, 2'b00);
        step(1); chk("tick05_en",  8'h05, 1, 0, 0, 2'b01);
        stop = 1'b1;
        step(1); stop = 1'b0;
        chk("stop_tick_done", 8'h06, 0, 1, 0, 2'b00);
        start = 1'b1;
        step(1); start = 1'b0;
        chk("done_ign_start", 8'h06, 0, 1, 0, 2'b00);

        // Target 0x00 with full wrap
        load = 1'b1; load_value = 8'h99; target = 8'h00;
        step(1); load = 1'b0; start = 1'b1;
        step(1); start = 1'b0;
        step(1); chk("t0_carry",   8'h99, 1, 0, 0, 2'b11);
        step(1); chk("ovf_done",   8'h00, 0, 1, 1, 2'b00);
        step(1); chk("ovf_done2",  8'h00, 0, 1, 0, 2'b00);

        // Asynchronous reset mid-RUN
        clear = 1'b1; target = 8'h50;
        step(1); clear = 1'b0;
        chk("clr_idle",   8'h00, 0, 0, 0, 2'b00);
        start = 1'b1;
        step(1); start = 1'b0;
        step(2); chk("pre_rst01",  8'h01, 1, 0, 0, 2'b00);
        step(1); #1 rst_n = 1'b0;
        chk("async_rst",  8'h00, 0, 0, 0, 2'b00);
        step(1); chk("rst_held",   8'h00, 0, 0, 0, 2'b00);
        rst_n = 1'b1; start = 1'b1;
        step(1); start = 1'b0;
        chk("restart",    8'h00, 1, 0, 0, 2'b00);
        step(1); chk("restart_en", 8'h00, 1, 0, 0, 2'b01);
        step(1); chk("restart01",  8'h01, 1, 0, 0, 2'b00);

        step(2);
        if (sb.size() > 0) begin
            $display("FAIL scoreboard_drain: got %0d unchecked entries, want 0", sb.size());
            checks++;
            errors++;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_cascade_ctrl.md
Name: bcd_cascade_ctrl

Overview:
Sequencing controller for a cascade of synchronous decade (BCD) counter digits. It owns a prescaler that generates the count tick and the per-digit carry enables. It also handles start/stop/clear/load control, target compare and overflow detection. It sits between the system control logic and the displayed BCD count, replacing ad-hoc per-digit reset/preset wiring with one state machine.

Parameters:
DIGITS, 4, number of cascaded BCD digits (1..8)
PRESCALE, 10, Clock cycles per count tick (2..65535)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  level, sampled each cycle; begin/resume counting
Stop  input  1  level; pause counting
Clear  input  1  level; zero count and prescaler, go IDLE
Load  input  1  level; load LoadValue into count, go IDLE
LoadValue  input  4*DIGITS  BCD preset value, digit 0 in bits [3:0]
Target  input  4*DIGITS  BCD terminal value for Done
Count  output  4*DIGITS  registered BCD count
DigitEn  output  DIGITS  combinational; bit k = digit k increments at this edge
Running  output  1  registered; 1 in RUN
Done  output  1  registered; 1 in DONE
Overflow  output  1  registered one-cycle pulse on full-cascade wrap

Behaviour:
- Reset low (async): state IDLE, Count=0, prescaler=0, Running=0, Done=0, Overflow=0. Release is synchronous to the next Clock edge.
- States: IDLE, RUN, PAUSE, DONE. Running = (state==RUN). Done = (state==DONE).
- Command priority per cycle: Clear > Load > Stop > Start. Only the highest asserted command acts.
- Clear (any state): Count=0, prescaler=0, next state IDLE.
- Load (any state): Count=LoadValue, prescaler=0, next state IDLE. Any loaded digit >9 is stored as 0.
- Stop: RUN->PAUSE; prescaler and Count hold. Ignored in other states.
- Start: IDLE->RUN, PAUSE->RUN (prescaler resumes from its held value). Ignored in RUN and DONE; only Clear or Load leave DONE.
- Prescaler:
  - Counts 0..PRESCALE-1 only in RUN and wraps to 0.
  - tick = RUN & (prescaler==PRESCALE-1).
  - The first tick after Start from IDLE occurs on the PRESCALE-th RUN cycle.
- Carry chain: DigitEn[0]=tick; DigitEn[k]=DigitEn[k-1] & (digit k-1 == 9). DigitEn is 0 outside RUN.
- Digit update: an enabled digit goes d -> d+1, except 9 -> 0. The whole cascade updates at the same edge; Count reflects it one cycle after DigitEn.
- Overflow: when tick and all digits ==9, Count goes to 0 and Overflow=1 for exactly one cycle; counting continues.
- Target compare:
  - Evaluated only on the post-increment value at a tick.
  - If the new Count == Target, next state is DONE, Running=0 and the prescaler holds.
  - If Count already equals Target at Start, Done is not raised until the count wraps back to Target.
- Simultaneous overflow and target match (Target=0): both Overflow pulses and DONE is entered.
- Stop in the same cycle as a tick: Stop wins the state transition, but the tick's increment still completes. If that increment matches Target, DONE wins over PAUSE.
- Async Reset mid-RUN: all outputs return to reset values immediately, with no pending tick.

Test Plan:
1. DIGITS=2, PRESCALE=2. Assert then release Reset -> Count=0x00, Running=0, Done=0, Overflow=0, DigitEn=00.
2. Target=0x12, pulse Start -> Running=1. Count increments every 2 cycles: 0x01 after cycle 2, 0x09->0x10 with DigitEn=11 on that tick. Count=0x12 and Done=1, Running=0 after tick 12; Count holds 0x12.
3. Load 0x98, Target=0x50, Start -> ticks give 0x99, then 0x00 with Overflow=1 for one cycle; next tick gives 0x01, Overflow=0.
4. Run to Count=0x03 with prescaler=1, assert Stop -> PAUSE, Count holds 0x03 for 10 cycles. Start -> 0x04 on the first RUN cycle (prescaler preserved).
5. Clear+Load+Start in the same cycle while RUN at 0x07 -> Count=0x00, IDLE, Running=0. Load with LoadValue=0x3A -> Count=0x30.
6. Drop Reset asynchronously mid-RUN between clock edges -> Count=0, Running=0 before the next edge. After release, Start restarts from 0 with the full PRESCALE delay.
